// File: rtl/button_ctrl_pkg.sv
// Shared constants and register decode for the push-button peripheral.
// Optional interrupt support is enabled with the BTN_IRQ_EN macro.
package button_ctrl_pkg;

    localparam logic [3:0] BTN_OFF_STATUS  = 4'h0;
    localparam logic [3:0] BTN_OFF_PENDING = 4'h4;
    localparam logic [3:0] BTN_OFF_CTRL    = 4'h8;

    localparam int BTN_DEBOUNCE_DEFAULT = 200000;

    // Window base seen by the bridge select decode.
    localparam logic [31:0] BTN_BASE_ADDR = 32'h4000_0200;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_PENDING = 2'd1,
        REG_CTRL    = 2'd2,
        REG_RSVD    = 2'd3
    } btn_reg_e;

    function automatic btn_reg_e btn_decode(input logic [1:0] word);
        return btn_reg_e'(word);
    endfunction

endpackage

// File: rtl/button_ctrl_if.sv
// Bridge-side register bus for the push-button peripheral.
// Byte offset in, combinational read data out.
interface button_ctrl_if;

    logic        wen;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output wen,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  wen,
        input  addr,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter, stable level
// and a single-cycle pulse coincident with the edge that accepts a press.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rstn,
    input  logic button_i,
    output logic stable_o,
    output logic rise_o
);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             differ;
    logic             done;

    assign differ = sync2_q != stable_q;
    assign done   = differ && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));

    // Any sample matching the stable level restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (done) begin
            stable_d = sync2_q;
        end else if (differ) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= button_i;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = done & sync2_q;

endmodule

// File: rtl/button_ctrl.sv
// Memory-mapped push-button peripheral: STATUS, W1C PENDING and CTRL.
// Define BTN_IRQ_EN to add the irq port and the CTRL mask register.
module button_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int NUM_BTN         = 5,
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_BTN-1:0] button,
`ifdef BTN_IRQ_EN
    output logic               irq,
`endif
    button_ctrl_if.slave       bus
);

    logic [NUM_BTN-1:0] stable;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pending_q;
    logic [NUM_BTN-1:0] pending_d;
    logic [NUM_BTN-1:0] clr;
    logic [NUM_BTN-1:0] ctrl_rd;
    logic [31:0]        rd_mux;
    btn_reg_e           sel;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_deb (
            .clk      (clk),
            .rstn     (rstn),
            .button_i (button[i]),
            .stable_o (stable[i]),
            .rise_o   (rise[i])
        );
    end

    assign sel = btn_decode(bus.addr[3:2]);
    assign clr = (bus.wen && sel == REG_PENDING) ?
                 bus.wdata[NUM_BTN-1:0] : '0;

    // A press on the same edge as a clear of that bit must survive.
    assign pending_d = (pending_q & ~clr) | rise;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef BTN_IRQ_EN
    logic [NUM_BTN-1:0] mask_q;
    logic [NUM_BTN-1:0] mask_d;
    logic               irq_q;
    logic               irq_d;

    assign mask_d = (bus.wen && sel == REG_CTRL) ?
                    bus.wdata[NUM_BTN-1:0] : mask_q;
    assign irq_d  = |(pending_q & mask_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq     = irq_q;
    assign ctrl_rd = mask_q;
`else
    assign ctrl_rd = '0;
`endif

    always_comb begin
        rd_mux = '0;
        unique case (sel)
            REG_STATUS:  rd_mux[NUM_BTN-1:0] = stable;
            REG_PENDING: rd_mux[NUM_BTN-1:0] = pending_q;
            REG_CTRL:    rd_mux[NUM_BTN-1:0] = ctrl_rd;
            REG_RSVD:    rd_mux = '0;
            default:     rd_mux = '0;
        endcase
    end

    assign bus.rdata = rd_mux;

    logic unused_ok;
    assign unused_ok = ^{bus.addr[1:0], bus.wdata[31:NUM_BTN]};

endmodule

// File: tb/tb_button_ctrl.sv
// Scoreboard bench for button_ctrl with a 4-cycle debounce window.
// Define BTN_IRQ_EN to also exercise the interrupt path.
module tb_button_ctrl;
    import button_ctrl_pkg::*;

    localparam int DEB = 4;
    localparam int LAT = DEB + 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic [4:0] button;
`ifdef BTN_IRQ_EN
    logic       irq;
`endif

    button_ctrl_if bus ();

    button_ctrl #(
        .NUM_BTN         (5),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .button (button),
`ifdef BTN_IRQ_EN
        .irq    (irq),
`endif
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [3:0]  a;
        logic [31:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] rd_v;
    int          vectors     = 0;
    int          miscompares = 0;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rdata;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.wen   = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.wen   = 1'b0;
        bus.wdata = '0;
    endtask

    task automatic test_reset();
        button = 5'b00001;
        tick(LAT);
        sb.push_back(exp_t'{"pre_rst_status", BTN_OFF_STATUS, 32'h1});
        sb.push_back(exp_t'{"pre_rst_pending", BTN_OFF_PENDING, 32'h1});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.a, rd_v); vectors++;
            if (rd_v !== e.v) begin miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, rd_v, e.v); end
        end
        rstn = 1'b0;
        #1;
        sb.push_back(exp_t'{"rst_status", BTN_OFF_STATUS, 32'h0});
        sb.push_back(exp_t'{"rst_pending", BTN_OFF_PENDING, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.a, rd_v); vectors++;
            if (rd_v !== e.v) begin miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, rd_v, e.v); end
        end
        tick(2);
        rstn = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            sb.push_back(exp_t'{"rearm_status", BTN_OFF_STATUS,
                                (k == LAT) ? 32'h1 : 32'h0});
            sb.push_back(exp_t'{"rearm_pending", BTN_OFF_PENDING,
                                (k == LAT) ? 32'h1 : 32'h0});
            while (sb.size() > 0) begin
                e = sb.pop_front(); rd(e.a, rd_v); vectors++;
                if (rd_v !== e.v) begin miscompares++;
                    $display("FAIL %s k=%0d: got %h expected %h",
                             e.nm, k, rd_v, e.v); end
            end
        end
        button = 5'b00000;
        tick(LAT);
        wr(BTN_OFF_PENDING, 32'h1f);
    endtask

    task automatic test_clean_press();
        button = 5'b00001;
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            sb.push_back(exp_t'{"press_status", BTN_OFF_STATUS,
                                (k == LAT) ? 32'h1 : 32'h0});
            sb.push_back(exp_t'{"press_pending", BTN_OFF_PENDING,
                                (k == LAT) ? 32'h1 : 32'h0});
            while (sb.size() > 0) begin
                e = sb.pop_front(); rd(e.a, rd_v); vectors++;
                if (rd_v !== e.v) begin miscompares++;
                    $display("FAIL %s k=%0d: got %h expected %h",
                             e.nm, k, rd_v, e.v); end
            end
        end
        button = 5'b00000;
        for (int k = 1; k <= LAT; k++) begin
            tick(1);
            sb.push_back(exp_t'{"release_status", BTN_OFF_STATUS,
                                (k == LAT) ? 32'h0 : 32'h1});
            sb.push_back(exp_t'{"release_pending", BTN_OFF_PENDING, 32'h1});
            while (sb.size() > 0) begin
                e = sb.pop_front(); rd(e.a, rd_v); vectors++;
                if (rd_v !== e.v) begin miscompares++;
                    $display("FAIL %s k=%0d: got %h expected %h",
                             e.nm, k, rd_v, e.v); end
            end
        end
        wr(BTN_OFF_PENDING, 32'h1);
    endtask

    task automatic test_bounce();
        for (int j = 0; j < 8; j++) begin
            button[2] = ((j / 2) % 2) == 0;
            tick(1);
            sb.push_back(exp_t'{"bounce_status", BTN_OFF_STATUS, 32'h0});
            sb.push_back(exp_t'{"bounce_pending", BTN_OFF_PENDING, 32'h0});
            while (sb.size() > 0) begin
                e = sb.pop_front(); rd(e.a, rd_v); vectors++;
                if (rd_v !== e.v) begin miscompares++;
                    $display("FAIL %s j=%0d: got %h expected %h",
                             e.nm, j, rd_v, e.v); end
            end
        end
        button[2] = 1'b1;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick(1);
            sb.push_back(exp_t'{"settle_status", BTN_OFF_STATUS,
                                (k >= LAT) ? 32'h4 : 32'h0});
            sb.push_back(exp_t'{"settle_pending", BTN_OFF_PENDING,
                                (k >= LAT) ? 32'h4 : 32'h0});
            while (sb.size() > 0) begin
                e = sb.pop_front(); rd(e.a, rd_v); vectors++;
                if (rd_v !== e.v) begin miscompares++;
                    $display("FAIL %s k=%0d: got %h expected %h",
                             e.nm, k, rd_v, e.v); end
            end
        end
    endtask

    task automatic test_w1c();
        wr(BTN_OFF_PENDING, 32'h4);
        button = 5'b10111;
        tick(LAT);
        sb.push_back(exp_t'{"w1c_setup_status", BTN_OFF_STATUS, 32'h17});
        sb.push_back(exp_t'{"w1c_setup_pending", BTN_OFF_PENDING, 32'h13});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.a, rd_v); vectors++;
            if (rd_v !== e.v) begin miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, rd_v, e.v); end
        end
        wr(BTN_OFF_PENDING, 32'h2);
        sb.push_back(exp_t'{"w1c_bit1", BTN_OFF_PENDING, 32'h11});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.a, rd_v); vectors++;
            if (rd_v !== e.v) begin miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, rd_v, e.v); end
        end
        wr(BTN_OFF_PENDING, 32'h0);
        sb.push_back(exp_t'{"w1c_zero", BTN_OFF_PENDING, 32'h11});
        wr(BTN_OFF_STATUS, 32'hffff_ffff);
        sb.push_back(exp_t'{"status_ro", BTN_OFF_STATUS, 32'h17});
        sb.push_back(exp_t'{"status_wr_pend", BTN_OFF_PENDING, 32'h11});
        wr(4'hc, 32'hffff_ffff);
        sb.push_back(exp_t'{"rsvd_reads0", 4'hc, 32'h0});
`ifndef BTN_IRQ_EN
        wr(BTN_OFF_CTRL, 32'h1f);
        sb.push_back(exp_t'{"ctrl_reads0", BTN_OFF_CTRL, 32'h0});
`endif
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.a, rd_v); vectors++;
            if (rd_v !== e.v) begin miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, rd_v, e.v); end
        end
        button = 5'b00000;
        tick(LAT);
        wr(BTN_OFF_PENDING, 32'h1f);
        sb.push_back(exp_t'{"w1c_clean_status", BTN_OFF_STATUS, 32'h0});
        sb.push_back(exp_t'{"w1c_clean_pending", BTN_OFF_PENDING, 32'h0});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.a, rd_v); vectors++;
            if (rd_v !== e.v) begin miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, rd_v, e.v); end
        end
    endtask

    task automatic test_collision();
        button = 5'b00010;
        tick(LAT - 1);
        wr(BTN_OFF_PENDING, 32'h2);
        sb.push_back(exp_t'{"coll_status", BTN_OFF_STATUS, 32'h2});
        sb.push_back(exp_t'{"coll_pending", BTN_OFF_PENDING, 32'h2});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.a, rd_v); vectors++;
            if (rd_v !== e.v) begin miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, rd_v, e.v); end
        end
        button = 5'b00000;
        tick(LAT);
        wr(BTN_OFF_PENDING, 32'h1f);
    endtask

`ifdef BTN_IRQ_EN
    task automatic test_irq();
        logic exp_irq;
        wr(BTN_OFF_CTRL, 32'h1);
        sb.push_back(exp_t'{"ctrl_rw", BTN_OFF_CTRL, 32'h1});
        while (sb.size() > 0) begin
            e = sb.pop_front(); rd(e.a, rd_v); vectors++;
            if (rd_v !== e.v) begin miscompares++;
                $display("FAIL %s: got %h expected %h", e.nm, rd_v, e.v); end
        end
        button = 5'b00001;
        for (int k = 1; k <= LAT + 1; k++) begin
            tick(1);
            exp_irq = (k == LAT + 1);
            vectors++;
            if (irq !== exp_irq) begin miscompares++;
                $display("FAIL irq_assert k=%0d: got %b expected %b",
                         k, irq, exp_irq); end
        end
        wr(BTN_OFF_PENDING, 32'h1);
        vectors++;
        if (irq !== 1'b1) begin miscompares++;
            $display("FAIL irq_clr_lag: got %b expected 1", irq); end
        tick(1);
        vectors++;
        if (irq !== 1'b0) begin miscompares++;
            $display("FAIL irq_clr: got %b expected 0", irq); end
        button = 5'b01001;
        for (int k = 1; k <= LAT + 2; k++) begin
            tick(1);
            vectors++;
            if (irq !== 1'b0) begin miscompares++;
                $display("FAIL irq_masked k=%0d: got %b expected 0", k, irq); end
        end
        wr(BTN_OFF_CTRL, 32'h8);
        tick(1);
        vectors++;
        if (irq !== 1'b1) begin miscompares++;
            $display("FAIL irq_mask_set: got %b expected 1", irq); end
        wr(BTN_OFF_CTRL, 32'h0);
        tick(1);
        vectors++;
        if (irq !== 1'b0) begin miscompares++;
            $display("FAIL irq_mask_clr: got %b expected 0", irq); end
        button = 5'b00000;
        tick(LAT);
        wr(BTN_OFF_PENDING, 32'h1f);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn      = 1'b0;
        button    = '0;
        bus.wen   = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        tick(2);
        vectors++;
        if (bus.rdata !== 32'h0) begin miscompares++;
            $display("FAIL por_rdata: got %h expected 0", bus.rdata); end
        rstn = 1'b1;
        tick(1);
        test_reset();
        test_clean_press();
        test_bounce();
        test_w1c();
        test_collision();
`ifdef BTN_IRQ_EN
        test_irq();
`endif
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
